// File: rtl/tx_byte_fifo_if.sv
// Handshake bundle for tx_byte_fifo. The master side is the environment
// around the FIFO (packer writes plus the UART busy line). The slave side is
// the FIFO itself.
interface tx_byte_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_uart;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  tx_busy;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] t_data;
  logic                  overflow;

  modport master (
    output wr_uart, w_data, tx_busy,
    input  full, empty, count, tx_start, t_data, overflow
  );

  modport slave (
    input  wr_uart, w_data, tx_busy,
    output full, empty, count, tx_start, t_data, overflow
  );
endinterface

// File: rtl/tx_byte_fifo.sv
// tx_byte_fifo: circular byte FIFO between the debugger transmit packer and
// the UART transmitter. A four-state drain sequencer launches one byte at a
// time with a single-cycle tx_start pulse. It waits for the UART to
// acknowledge the launch by raising tx_busy. If tx_busy never rises within
// ACK_TIMEOUT cycles, the sequencer gives up on that byte and does not retry.
// Optional feature macro: TXFIFO_OVERFLOW_FLAG_EN. When it is defined, a sticky
// write-while-full flag is built. When it is undefined, the overflow output
// is tied low.
module tx_byte_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input logic           clock,
  input logic           reset,
  tx_byte_fifo_if.slave bus
);

  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [7:0]          TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic [ADDR_WIDTH:0]   occ;
  logic [7:0]            tmo;
  logic                  tx_start_q;
  logic [DATA_WIDTH-1:0] t_data_q;

  logic full;
  logic empty;
  logic wr_acc;
  logic pop;

  // full and empty come straight from the registered occupancy.
  // A write into a full FIFO is dropped, even if a pop happens in the same cycle.
  assign full   = (occ == DEPTH_CNT);
  assign empty  = (occ == '0);
  assign wr_acc = bus.wr_uart && !full;
  assign pop    = (state == LAUNCH);

  // Storage write port
  // NOTE: the data array has no reset. Only the pointers and the count decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wp] <= bus.w_data;
  end

  // Write/read pointers (wrapping naturally modulo DEPTH) and occupancy count
  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (wr_acc) wp <= wp + 1'b1;
      if (pop)    rp <= rp + 1'b1;
      case ({wr_acc, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Drain sequencer with registered launch pulse and launch data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmo        <= '0;
      tx_start_q <= 1'b0;
      t_data_q   <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        IDLE: begin
          // Load the head byte on the way into LAUNCH, so t_data is already
          // valid during the tx_start cycle. rp advances at the end of LAUNCH.
          if (!empty && !bus.tx_busy) begin
            state      <= LAUNCH;
            tx_start_q <= 1'b1;
            t_data_q   <= mem[rp];
          end
        end
        LAUNCH: begin
          state <= WAIT_ACK;
          tmo   <= '0;
        end
        WAIT_ACK: begin
          // WAIT_ACK lasts at most ACK_TIMEOUT cycles. The counter reaches
          // ACK_TIMEOUT on the same edge that abandons the byte.
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo == TMO_LAST) state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TXFIFO_OVERFLOW_FLAG_EN
  logic overflow_q;

  // Sticky write-while-full flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     overflow_q <= 1'b0;
    else if (bus.wr_uart && full)   overflow_q <= 1'b1;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = occ;
  assign bus.tx_start = tx_start_q;
  assign bus.t_data   = t_data_q;

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Self-checking bench for tx_byte_fifo.
// The reference model is a byte queue plus an occupancy number. Bytes accepted
// by the rules go in. Each observed launch must carry the byte at the head of
// the queue.
module tb_tx_byte_fifo;

  localparam int DW          = 8;
  localparam int AW          = 4;
  localparam int DEPTH       = 1 << AW;
  localparam int ACK_TIMEOUT = 15;
`ifdef TXFIFO_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clock;
  logic reset;

  tx_byte_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  tx_byte_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // UART model controls: automatic busy response, or a level forced by the bench
  logic uart_auto;
  logic ub;
  logic bf;
  int   uart_lat;
  int   uart_len;
  assign bus.tx_busy = uart_auto ? ub : bf;

  // Reference model and bookkeeping
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         occ;
  int         n_starts;
  int         last_start;
  int         prev_start;
  logic       ovf_m;
  logic       prev_ts;
  logic       prev_busy;
  logic [7:0] last_td;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    bus.wr_uart = 1'b1;
    bus.w_data  = b;
    step();
    bus.wr_uart = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check("drain_budget", exp_q.size(), 0);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // UART: raise tx_busy uart_lat cycles after a launch, hold it for uart_len cycles
  initial begin
    ub = 1'b0;
    forever begin
      @(negedge clock);
      if (uart_auto && bus.tx_start && reset) begin
        repeat (uart_lat) @(posedge clock);
        #1 ub = 1'b1;
        repeat (uart_len) @(posedge clock);
        #1 ub = 1'b0;
      end
    end
  end

  // Monitor: runs every cycle, away from the active edge, against the model
  initial begin
    logic acc;
    occ = 0; ovf_m = 1'b0; prev_ts = 1'b0; prev_busy = 1'b0; last_td = '0;
    n_starts = 0; last_start = 0; prev_start = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        exp_q.delete();
        occ = 0; ovf_m = 1'b0; prev_ts = 1'b0; prev_busy = 1'b0; last_td = '0;
      end else begin
        check("count", bus.count, occ);
        check("full", bus.full, occ == DEPTH);
        check("empty", bus.empty, occ == 0);
        check("overflow", bus.overflow, ovf_m);
        check("start_pulse_width", bus.tx_start && prev_ts, 0);
        acc = bus.wr_uart && (occ < DEPTH);
        if (bus.tx_start) begin
          n_starts++;
          prev_start = last_start;
          last_start = cyc;
          check("launch_while_busy", prev_busy, 0);
          check("start_has_data", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) last_td = exp_q.pop_front();
          check("t_data_launch", bus.t_data, last_td);
          occ--;
        end else begin
          check("t_data_hold", bus.t_data, last_td);
        end
        if (acc) begin
          exp_q.push_back(bus.w_data);
          occ++;
        end else if (bus.wr_uart && OVF_EN) begin
          ovf_m = 1'b1;
        end
        prev_ts   = bus.tx_start;
        prev_busy = bus.tx_busy;
      end
    end
  end

  // Global watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Directed sequence
  initial begin
    int n0;
    int thr;
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b0; bus.wr_uart = 1'b0; bus.w_data = '0;
    uart_auto = 1'b0; bf = 1'b0; uart_lat = 2; uart_len = 10;

    // Reset state
    repeat (3) step();
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_t_data", bus.t_data, 0);
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);
    reset = 1'b1;
    repeat (2) step();

    // Single byte: launch one cycle after the write edge
    uart_auto = 1'b1; uart_lat = 2; uart_len = 10;
    n0 = n_starts;
    put(8'hA5);
    check("single_no_early_start", bus.tx_start, 0);
    step();
    check("single_start", bus.tx_start, 1);
    check("single_t_data", bus.t_data, 8'hA5);
    step();
    check("single_start_drop", bus.tx_start, 0);
    repeat (30) step();
    check("single_empty_after", bus.empty, 1);
    check("single_one_launch", n_starts - n0, 1);

    // Burst into a blocked UART: 16 accepted, 17th dropped
    uart_auto = 1'b0; bf = 1'b1;
    for (int i = 0; i < 17; i++) begin
      put(8'(i));
      if (i == 15) begin
        check("burst_full", bus.full, 1);
        check("burst_count16", bus.count, 16);
      end
    end
    check("burst_count_after_drop", bus.count, 16);
    check("burst_overflow", bus.overflow, OVF_EN);
    n0 = n_starts;
    uart_lat = 1; uart_len = 3; bf = 1'b0; uart_auto = 1'b1;
    wait_drain(2000);
    repeat (20) step();
    check("burst_launches", n_starts - n0, 16);

    // Wrap: 40 bytes in groups of 5 interleaved with partial draining
    n0 = n_starts;
    for (int g = 0; g < 8; g++) begin
      uart_lat = $urandom_range(1, 2);
      uart_len = $urandom_range(1, 4);
      for (int j = 0; j < 5; j++) put(8'($urandom));
      thr = $urandom_range(0, 8);
      for (int k = 0; k < 500 && exp_q.size() > thr; k++) step();
    end
    wait_drain(2000);
    repeat (20) step();
    check("wrap_launches", n_starts - n0, 40);

    // Write during LAUNCH with count 3: occupancy holds
    uart_auto = 1'b0; bf = 1'b1;
    put(8'h31); put(8'h32); put(8'h33);
    check("simul_count_pre", bus.count, 3);
    uart_lat = 2; uart_len = 3;
    bf = 1'b0; uart_auto = 1'b1;
    step();
    check("simul_in_launch", bus.tx_start, 1);
    put(8'h34);
    check("simul_count_held", bus.count, 3);
    wait_drain(500);
    repeat (20) step();

    // Timeout: tx_busy stuck low, each byte launched once
    uart_auto = 1'b0; bf = 1'b0;
    n0 = n_starts;
    put(8'h11);
    put(8'h22);
    repeat (60) step();
    check("tmo_launches", n_starts - n0, 2);
    check("tmo_gap", last_start - prev_start, ACK_TIMEOUT + 2);
    check("tmo_empty", bus.empty, 1);

    // Reset during WAIT_DONE with 5 bytes queued
    uart_auto = 1'b1; uart_lat = 1; uart_len = 30;
    for (int i = 0; i < 6; i++) put(8'h50 + 8'(i));
    check("mid_count_pre", bus.count, 5);
    step();
    #2 reset = 1'b0;
    #1;
    check("mid_tx_start", bus.tx_start, 0);
    check("mid_t_data", bus.t_data, 0);
    check("mid_count", bus.count, 0);
    check("mid_empty", bus.empty, 1);
    check("mid_full", bus.full, 0);
    check("mid_overflow", bus.overflow, 0);
    step();
    reset = 1'b1;
    n0 = n_starts;
    repeat (50) step();
    check("mid_no_launch", n_starts - n0, 0);
    uart_lat = 2; uart_len = 4;
    put(8'h3C);
    wait_drain(100);
    repeat (20) step();
    check("mid_new_launch", n_starts - n0, 1);

    // Randomized traffic against the model, including fill-ups and drops
    for (int c = 0; c < 400; c++) begin
      if (c % 50 == 0) begin
        uart_lat = $urandom_range(1, 3);
        uart_len = $urandom_range(1, 12);
      end
      bus.wr_uart = ($urandom_range(0, 99) < 50);
      bus.w_data  = 8'($urandom);
      step();
    end
    bus.wr_uart = 1'b0;
    wait_drain(3000);
    repeat (30) step();
    check("rand_final_empty", bus.empty, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
